// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: front-panel time-set controller and DST adjuster for the
// 1 kHz hr/min/sec/ms timekeeper.
// Optional feature macro: CLOCK_SET_SEC_EN (adds SET_SEC state, cur_sec/load_sec).

// Per-button synchronizer, debounce and (optional) auto-repeat press pulse.
module clock_set_btn #(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter bit REPEAT_EN   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q;
  logic          acc_q;
  logic [DW-1:0] db_q;
  logic          rise;

  // Two-flop synchronizer, then accept a new level after DEBOUNCE_MS differing cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      acc_q  <= 1'b0;
      db_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] != acc_q) begin
        if (db_q == DB_LAST) begin
          acc_q <= sync_q[1];
          db_q  <= '0;
        end else begin
          db_q <= db_q + DW'(1);
        end
      end else begin
        db_q <= '0;
      end
    end
  end

  // Pulse in the cycle the accepted level is about to go high.
  assign rise = sync_q[1] & ~acc_q & (db_q == DB_LAST);

  if (REPEAT_EN) begin : g_rpt
    localparam int RMAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int RW   = $clog2(RMAX + 1);
    logic          rep_q;
    logic [RW-1:0] rc_q;
    logic          rpt;

    // First repeat after HOLD_MS held cycles, then one every REPEAT_MS.
    assign rpt = acc_q & (rep_q ? (rc_q == RW'(REPEAT_MS - 1))
                                : (rc_q == RW'(HOLD_MS - 1)));

    // Hold/repeat timer; release clears it, each repeat pulse reloads it.
    always_ff @(posedge clk_i) begin
      if (rst_i || !acc_q) begin
        rep_q <= 1'b0;
        rc_q  <= '0;
      end else if (rpt) begin
        rep_q <= 1'b1;
        rc_q  <= '0;
      end else begin
        rc_q <= rc_q + RW'(1);
      end
    end

    assign press_o = rise | rpt;
  end else begin : g_norpt
    assign press_o = rise;
  end
endmodule

module clock_set_ctrl #(
  parameter int HOUR_MAX    = 23,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter int TIMEOUT_MS  = 10000,
  parameter int BLINK_MS    = 250
) (
  input  logic       kh_clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       spring_szn,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
`ifdef CLOCK_SET_SEC_EN
  input  logic [5:0] cur_sec,
  output logic [5:0] load_sec,
`endif
  output logic       run_en,
  output logic       load,
  output logic       load_hr_only,
  output logic [4:0] load_hr,
  output logic [5:0] load_min,
  output logic [1:0] mode_state,
  output logic       blink
);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_MS - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_MS - 1);
  localparam logic [4:0]    HMAX    = 5'(HOUR_MAX);

  typedef enum logic [2:0] {S_RUN, S_HR, S_MIN, S_SEC, S_COMMIT} state_t;

  function automatic logic [4:0] hr_step(input logic [4:0] h, input logic up);
    if (up) return (h >= HMAX) ? 5'd0 : h + 5'd1;
    else    return (h == 5'd0 || h > HMAX) ? HMAX : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
    if (up) return (m >= 6'd59) ? 6'd0 : m + 6'd1;
    else    return (m == 6'd0 || m > 6'd59) ? 6'd59 : m - 6'd1;
  endfunction

  logic [2:0] btn_raw, press;
  logic       p_mode, p_any, p_inc, p_dec, dst;
  logic       set_q, set_d;

  state_t        state_q, state_d;
  logic [4:0]    ehr_q, ehr_d, lhr_q, lhr_d;
  logic [5:0]    emin_q, emin_d, lmin_q, lmin_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          load_q, load_d, lho_q, lho_d, sprev_q;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;
`ifdef CLOCK_SET_SEC_EN
  logic [5:0]    esec_q, esec_d, lsec_q, lsec_d;
`endif

  assign btn_raw = {btn_down, btn_up, btn_mode};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    clock_set_btn #(
      .DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS),
      .REPEAT_EN(i != 0)
    ) u_btn (
      .clk_i(kh_clk), .rst_i(reset), .btn_i(btn_raw[i]), .press_o(press[i])
    );
  end

  // Mode wins; simultaneous up and down cancel each other.
  assign p_mode = press[0];
  assign p_any  = |press;
  assign p_inc  = press[1] & ~press[2] & ~p_mode;
  assign p_dec  = press[2] & ~press[1] & ~p_mode;
  assign dst    = spring_szn ^ sprev_q;
  assign set_q  = (state_q == S_HR) || (state_q == S_MIN) || (state_q == S_SEC);
  assign set_d  = (state_d == S_HR) || (state_d == S_MIN) || (state_d == S_SEC);

  // Next-state, field edits, idle timeout and load strobe generation.
  always_comb begin
    state_d = state_q;
    ehr_d   = ehr_q;
    emin_d  = emin_q;
    idle_d  = '0;
    load_d  = 1'b0;
    lho_d   = 1'b0;
    lhr_d   = lhr_q;
    lmin_d  = lmin_q;
`ifdef CLOCK_SET_SEC_EN
    esec_d  = esec_q;
    lsec_d  = lsec_q;
`endif
    case (state_q)
      S_RUN: if (p_mode) begin
        ehr_d   = cur_hr;
        emin_d  = cur_min;
`ifdef CLOCK_SET_SEC_EN
        esec_d  = cur_sec;
`endif
        state_d = S_HR;
      end
      S_HR: begin
        if (p_mode)     state_d = S_MIN;
        else if (p_inc) ehr_d = hr_step(ehr_q, 1'b1);
        else if (p_dec) ehr_d = hr_step(ehr_q, 1'b0);
      end
      S_MIN: begin
        if (p_mode) begin
`ifdef CLOCK_SET_SEC_EN
          state_d = S_SEC;
`else
          state_d = S_COMMIT;
          load_d  = 1'b1;
          lhr_d   = ehr_q;
          lmin_d  = emin_q;
`endif
        end
        else if (p_inc) emin_d = min_step(emin_q, 1'b1);
        else if (p_dec) emin_d = min_step(emin_q, 1'b0);
      end
`ifdef CLOCK_SET_SEC_EN
      S_SEC: begin
        if (p_mode) begin
          state_d = S_COMMIT;
          load_d  = 1'b1;
          lhr_d   = ehr_q;
          lmin_d  = emin_q;
          lsec_d  = esec_q;
        end
        else if (p_inc) esec_d = min_step(esec_q, 1'b1);
        else if (p_dec) esec_d = min_step(esec_q, 1'b0);
      end
`endif
      S_COMMIT: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
    // Abandon edits after TIMEOUT_MS pulse-free cycles in a SET state.
    if (set_q) begin
      if (p_any)                 idle_d  = '0;
      else if (idle_q == TO_LAST) state_d = S_RUN;
      else                       idle_d  = idle_q + TW'(1);
    end
    // DST edges only adjust the live time; edits in progress are authoritative.
    if (state_q == S_RUN && dst) begin
      load_d = 1'b1;
      lho_d  = 1'b1;
      lhr_d  = hr_step(cur_hr, spring_szn);
      lmin_d = cur_min;
    end
  end

  // State, edit buffers, load outputs and season history.
  always_ff @(posedge kh_clk) begin
    if (reset) begin
      state_q <= S_RUN;
      ehr_q   <= '0;
      emin_q  <= '0;
      idle_q  <= '0;
      load_q  <= 1'b0;
      lho_q   <= 1'b0;
      lhr_q   <= '0;
      lmin_q  <= '0;
      sprev_q <= spring_szn;
`ifdef CLOCK_SET_SEC_EN
      esec_q  <= '0;
      lsec_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ehr_q   <= ehr_d;
      emin_q  <= emin_d;
      idle_q  <= idle_d;
      load_q  <= load_d;
      lho_q   <= lho_d;
      lhr_q   <= lhr_d;
      lmin_q  <= lmin_d;
      sprev_q <= spring_szn;
`ifdef CLOCK_SET_SEC_EN
      esec_q  <= esec_d;
      lsec_q  <= lsec_d;
`endif
    end
  end

  // Blink phase restarts low on every SET-state entry, forced low elsewhere.
  always_ff @(posedge kh_clk) begin
    if (reset || !set_d || state_d != state_q) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (bcnt_q == BL_LAST) begin
      bcnt_q  <= '0;
      blink_q <= ~blink_q;
    end else begin
      bcnt_q <= bcnt_q + BW'(1);
    end
  end

  // Field indicator; COMMIT reports as RUN.
  always_comb begin
    mode_state = 2'b00;
    case (state_q)
      S_HR:    mode_state = 2'b01;
      S_MIN:   mode_state = 2'b10;
      S_SEC:   mode_state = 2'b11;
      default: mode_state = 2'b00;
    endcase
  end

  assign run_en       = (state_q == S_RUN);
  assign load         = load_q;
  assign load_hr_only = lho_q;
  assign load_hr      = lhr_q;
  assign load_min     = lmin_q;
  assign blink        = blink_q;
`ifdef CLOCK_SET_SEC_EN
  assign load_sec     = lsec_q;
`endif
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: two instances (24 h and 12 h) share stimulus and
// are checked every cycle against a cycle-level behavioural model.
module tb_clock_set_ctrl;
  localparam int DEB = 2, HOLD = 8, REP = 3, TO = 50, BL = 4;

  logic       kh_clk = 1'b0;
  logic       reset, spring_szn;
  logic [2:0] bt;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;

  logic       run_en_w[2], load_w[2], lho_w[2], blink_w[2];
  logic [4:0] lhr_w[2];
  logic [5:0] lmin_w[2];
  logic [1:0] ms_w[2];

  always #5 kh_clk = ~kh_clk;

  clock_set_ctrl #(.HOUR_MAX(23), .DEBOUNCE_MS(DEB), .HOLD_MS(HOLD), .REPEAT_MS(REP),
                   .TIMEOUT_MS(TO), .BLINK_MS(BL)) dut (
    .kh_clk(kh_clk), .reset(reset), .btn_mode(bt[0]), .btn_up(bt[1]), .btn_down(bt[2]),
    .spring_szn(spring_szn), .cur_hr(cur_hr), .cur_min(cur_min),
    .run_en(run_en_w[0]), .load(load_w[0]), .load_hr_only(lho_w[0]), .load_hr(lhr_w[0]),
    .load_min(lmin_w[0]), .mode_state(ms_w[0]), .blink(blink_w[0]));

  clock_set_ctrl #(.HOUR_MAX(11), .DEBOUNCE_MS(DEB), .HOLD_MS(HOLD), .REPEAT_MS(REP),
                   .TIMEOUT_MS(TO), .BLINK_MS(BL)) dut12 (
    .kh_clk(kh_clk), .reset(reset), .btn_mode(bt[0]), .btn_up(bt[1]), .btn_down(bt[2]),
    .spring_szn(spring_szn), .cur_hr(cur_hr), .cur_min(cur_min),
    .run_en(run_en_w[1]), .load(load_w[1]), .load_hr_only(lho_w[1]), .load_hr(lhr_w[1]),
    .load_min(lmin_w[1]), .mode_state(ms_w[1]), .blink(blink_w[1]));

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b0;

  // model: buttons
  int acc[3], run[3], acc_t[3];
  bit sh1[3], sh2[3], sprev;
  int m_upp = 0;
  // model: per instance (st: 0 run, 1 set hour, 2 set minute; cm = commit cycle)
  int hmax[2] = '{23, 11};
  int st[2], ehr[2], emin[2], entry[2], last[2], mlhr[2], mlmin[2];
  bit cm[2], mld[2], mlho[2];
  // observed loads
  int nld[2], lg_hr[2], lg_min[2], lg_lho[2];

  function automatic int hwrap(int h, bit up, int hm);
    if (up) return (h >= hm) ? 0 : h + 1;
    return (h == 0) ? hm : h - 1;
  endfunction

  function automatic int mwrap(int m, bit up);
    if (up) return (m >= 59) ? 0 : m + 1;
    return (m == 0) ? 59 : m - 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit pl[3];
    bit y, ao, pm, anyp, inc, dec, dst;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin acc[b] = 0; run[b] = 0; sh1[b] = 0; sh2[b] = 0; end
      sprev = spring_szn;
      for (int k = 0; k < 2; k++) begin
        st[k] = 0; cm[k] = 0; mld[k] = 0; mlho[k] = 0; mlhr[k] = 0; mlmin[k] = 0;
      end
    end else begin
      for (int b = 0; b < 3; b++) begin
        y = sh2[b]; ao = (acc[b] != 0); pl[b] = 0;
        if (int'(y) != acc[b]) run[b]++; else run[b] = 0;
        if (run[b] == DEB) begin
          acc[b] = y; run[b] = 0;
          if (y) begin pl[b] = 1; acc_t[b] = cyc; end
        end
        if (b > 0 && ao && (cyc - acc_t[b]) >= HOLD && ((cyc - acc_t[b] - HOLD) % REP) == 0)
          pl[b] = 1;
        sh2[b] = sh1[b]; sh1[b] = bt[b];
      end
      if (pl[1]) m_upp++;
      pm = pl[0]; anyp = pl[0] | pl[1] | pl[2];
      inc = pl[1] & !pl[2] & !pm; dec = pl[2] & !pl[1] & !pm;
      dst = (spring_szn != sprev); sprev = spring_szn;
      for (int k = 0; k < 2; k++) begin
        mld[k] = 0; mlho[k] = 0;
        if (cm[k]) cm[k] = 0;
        else if (st[k] == 0) begin
          if (dst) begin
            mld[k] = 1; mlho[k] = 1; mlmin[k] = cur_min;
            mlhr[k] = hwrap(cur_hr, spring_szn, hmax[k]);
          end
          if (pm) begin
            st[k] = 1; ehr[k] = cur_hr; emin[k] = cur_min; entry[k] = cyc + 1; last[k] = cyc;
          end
        end else if (anyp) begin
          last[k] = cyc;
          if (pm) begin
            if (st[k] == 1) begin st[k] = 2; entry[k] = cyc + 1; end
            else begin st[k] = 0; cm[k] = 1; mld[k] = 1; mlhr[k] = ehr[k]; mlmin[k] = emin[k]; end
          end else if (inc || dec) begin
            if (st[k] == 1) ehr[k] = hwrap(ehr[k], inc, hmax[k]);
            else            emin[k] = mwrap(emin[k], inc);
          end
        end else if (cyc - last[k] == TO) st[k] = 0;
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge kh_clk);
    model_step();
  end

  // Compare process: every output of both instances, every cycle.
  initial forever begin
    @(negedge kh_clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("run_en%0d", k), int'(run_en_w[k]), int'(st[k] == 0 && !cm[k]));
        chk($sformatf("mode_state%0d", k), int'(ms_w[k]), st[k]);
        chk($sformatf("load%0d", k), int'(load_w[k]), int'(mld[k]));
        chk($sformatf("load_hr_only%0d", k), int'(lho_w[k]), int'(mlho[k]));
        chk($sformatf("load_hr%0d", k), int'(lhr_w[k]), mlhr[k]);
        chk($sformatf("load_min%0d", k), int'(lmin_w[k]), mlmin[k]);
        chk($sformatf("blink%0d", k), int'(blink_w[k]),
            (st[k] != 0) ? ((cyc - entry[k]) / BL) % 2 : 0);
        if (load_w[k]) begin
          nld[k]++; lg_hr[k] = lhr_w[k]; lg_min[k] = lmin_w[k]; lg_lho[k] = lho_w[k];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge kh_clk);
  endtask

  task automatic press(input logic [2:0] m, input int hold = 4, input int gap = 8);
    bt = m; tick(hold); bt = '0; tick(gap);
  endtask

  int n0, n1, p0, r;

  initial begin
    reset = 1'b1; spring_szn = 1'b1; bt = '0; cur_hr = 5'd0; cur_min = 6'd0;
    tick(1); chk_en = 1'b1;
    tick(9);
    chk("rst_run_en", int'(run_en_w[0]), 1);
    chk("rst_mode_state", int'(ms_w[0]), 0);
    reset = 1'b0;
    tick(5);
    chk("rst_no_load", nld[0] + nld[1], 0);

    // 5:30 -> up x2, down x1 -> 7:29
    n0 = nld[0]; cur_hr = 5'd5; cur_min = 6'd30;
    press(3'b001); chk("set_run_en_low", int'(run_en_w[0]), 0);
    press(3'b010); press(3'b010); press(3'b001); press(3'b100); press(3'b001);
    tick(4);
    chk("edit_load_count", nld[0] - n0, 1);
    chk("edit_load_hr", lg_hr[0], 7);
    chk("edit_load_min", lg_min[0], 29);
    chk("edit_load_hr_only", lg_lho[0], 0);

    // hour wrap: 12 h instance 11 -> 0, then 11 -> 0 -> 11 -> 10
    cur_hr = 5'd11; cur_min = 6'd0;
    press(3'b001); press(3'b010); press(3'b001); press(3'b001); tick(4);
    chk("wrap12_up", lg_hr[1], 0);
    chk("wrap24_up", lg_hr[0], 12);
    press(3'b001); press(3'b010); press(3'b100); press(3'b100);
    press(3'b001); press(3'b001); tick(4);
    chk("wrap12_down", lg_hr[1], 10);

    // glitch rejected; held up auto-repeats 58 -> 3
    cur_hr = 5'd3; cur_min = 6'd58;
    press(3'b001); press(3'b010, 1, 8); press(3'b001);
    p0 = m_upp; press(3'b010, 19, 10);
    chk("repeat_pulses", m_upp - p0, 5);
    press(3'b001); tick(4);
    chk("repeat_hr", lg_hr[0], 3);
    chk("repeat_min", lg_min[0], 3);

    // DST fall-back at hour 0, then spring-forward
    n0 = nld[0]; n1 = nld[1]; cur_hr = 5'd0; cur_min = 6'd17;
    spring_szn = 1'b0; tick(30);
    chk("dst_count", nld[0] - n0, 1);
    chk("dst_hr24", lg_hr[0], 23);
    chk("dst_hr12", lg_hr[1], 11);
    chk("dst_hr_only", lg_lho[0], 1);
    chk("dst_min", lg_min[1], 17);
    spring_szn = 1'b1; tick(5);
    chk("dst_fwd_hr", lg_hr[0], 1);
    chk("dst_fwd_count", nld[1] - n1, 2);

    // timeout abandons edits
    n0 = nld[0];
    press(3'b001); press(3'b010); tick(60);
    chk("timeout_mode", int'(ms_w[0]), 0);
    chk("timeout_run_en", int'(run_en_w[0]), 1);
    chk("timeout_no_load", nld[0] - n0, 0);

    // DST edge inside SET_MIN is dropped
    n0 = nld[0]; cur_hr = 5'd8; cur_min = 6'd15;
    press(3'b001); press(3'b001); spring_szn = 1'b0; tick(3);
    press(3'b001); tick(4);
    chk("setdst_count", nld[0] - n0, 1);
    chk("setdst_hr", lg_hr[0], 8);
    chk("setdst_min", lg_min[0], 15);
    chk("setdst_hr_only", lg_lho[0], 0);

    // randomized traffic against the model
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: press(3'b001 << $urandom_range(0, 2), $urandom_range(1, 25), $urandom_range(1, 15));
        5: press(3'b110, $urandom_range(3, 12), $urandom_range(3, 10));
        6: begin spring_szn = ~spring_szn; tick($urandom_range(1, 10)); end
        7: begin cur_hr = 5'($urandom_range(0, 11)); cur_min = 6'($urandom_range(0, 59)); tick(2); end
        8: if ($urandom_range(0, 3) == 0) begin
             reset = 1'b1; tick($urandom_range(1, 3)); reset = 1'b0; tick(2);
           end else tick($urandom_range(1, 60));
        default: tick($urandom_range(1, 60));
      endcase
    end
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Front-panel and season controller for the hr/min/sec/ms timekeeper that runs on the 1 kHz kh_clk.
- Debounces the mode/up/down buttons and sequences a time-set state machine.
- Gates the timekeeper's run enable and issues one-cycle load strobes carrying the edited time.
- Converts spring_szn level changes into a single ±1 hour adjustment. The timekeeper must never see a per-cycle adjust.

Parameters:
- HOUR_MAX, 23, highest hour value; 11 selects 12-hour operation (hours 0..11).
- DEBOUNCE_MS, 20, consecutive stable kh_clk cycles required before a button level is accepted.
- HOLD_MS, 500, cycles held before up/down auto-repeat starts.
- REPEAT_MS, 100, auto-repeat period once started.
- TIMEOUT_MS, 10000, idle cycles in a SET state before edits are abandoned.
- BLINK_MS, 250, blink half-period in SET states.

Ports:
- kh_clk  in  1  1 kHz system clock.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw mode button, active-high, asynchronous to kh_clk.
- btn_up  in  1  raw increment button.
- btn_down  in  1  raw decrement button.
- spring_szn  in  1  season level; 1 = daylight time.
- cur_hr  in  5  live hour from timekeeper.
- cur_min  in  6  live minute from timekeeper.
- run_en  out  1  timekeeper count enable.
- load  out  1  one-cycle load strobe.
- load_hr_only  out  1  qualifies load: 1 = replace hour only, keep min/sec/ms.
- load_hr  out  5  hour value for load.
- load_min  out  6  minute value for load.
- mode_state  out  2  00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC.
- blink  out  1  display blink for the field being edited.

Behaviour:
- Reset (synchronous, kh_clk rising edge, reset=1):
  - Outputs: run_en=1, load=0, load_hr_only=0, load_hr=0, load_min=0, mode_state=00, blink=0.
  - Internal: FSM=RUN, all debounce/repeat/timeout counters cleared, spring_prev loaded from spring_szn so no DST event fires on reset exit.
  - Reset mid-edit discards the edits and issues no load.
- Inputs pass through a 2-flop synchronizer before debounce.
- Debounce: the accepted level changes only after the synchronized input has differed from it for DEBOUNCE_MS consecutive cycles. Accepted 0->1 generates a one-cycle press pulse.
- Auto-repeat (up/down only):
  - After HOLD_MS cycles of accepted-high, a further pulse occurs every REPEAT_MS while held.
  - Releasing the button clears the repeat counters.
- Press priority in one cycle:
  - mode over up/down.
  - up and down pulsing in the same cycle are both ignored.
- FSM:
  - RUN: run_en=1. On mode: edit_hr<=cur_hr, edit_min<=cur_min, run_en<=0, go to SET_HR.
  - SET_HR: up increments edit_hr (HOUR_MAX wraps to 0); down decrements it (0 wraps to HOUR_MAX). mode goes to SET_MIN.
  - SET_MIN: edit_min wraps 0..59 both directions. mode goes to COMMIT.
  - COMMIT (transient, one cycle, mode_state=00, run_en=0): load=1, load_hr_only=0, load_hr=edit_hr, load_min=edit_min. The timekeeper zeroes sec/ms on a full load. Next cycle: RUN, run_en=1.
  - Timeout: in any SET state, TIMEOUT_MS cycles with no press pulse returns the FSM to RUN with run_en=1 and no load. The idle counter restarts on every pulse.
- Latency:
  - Mode press pulse to mode_state change: 1 cycle.
  - Third mode press to load: 1 cycle. load is asserted for exactly 1 cycle.
- DST:
  - A change in spring_szn versus spring_prev is an event.
  - 0->1 adds one hour; 1->0 subtracts one hour. Hours wrap at 0/HOUR_MAX.
  - In RUN: next cycle load=1, load_hr_only=1, load_hr=cur_hr±1 wrapped, load_min=cur_min.
  - In any SET state the event is discarded; the committed user time is authoritative. spring_prev still tracks the input.
  - A DST event and a COMMIT cannot coincide: COMMIT is reached only from SET states.
- blink: toggles every BLINK_MS in SET states, with the counter restarting at state entry. Forced to 0 in RUN/COMMIT.
- Counter widths: $clog2(param+1). No counter may wrap silently; each saturates or reloads.

Optional Feature:
- Macro: CLOCK_SET_SEC_EN.
- Defined:
  - Adds SET_SEC state (mode_state=11) between SET_MIN and COMMIT, and output load_sec[5:0].
  - Entering SET_HR also captures cur_sec, which arrives on additional input cur_sec[5:0].
  - In SET_SEC, up/down wrap edit_sec over 0..59. COMMIT drives load_sec=edit_sec.
  - In RUN, load_sec holds its last value.
- Undefined: no SET_SEC state and no cur_sec/load_sec ports. SET_MIN goes directly to COMMIT, and seconds are zeroed by the timekeeper.

Test Plan:
- Test parameters for all scenarios: DEBOUNCE_MS=2, HOLD_MS=8, REPEAT_MS=3, TIMEOUT_MS=50, BLINK_MS=4.
- Reset with spring_szn=1, hold 10 cycles -> run_en=1, load never asserts, mode_state=00.
- cur_hr=5, cur_min=30. Press mode, up ×2, mode, down ×1, mode -> exactly one load, with load_hr=7, load_min=29, load_hr_only=0. run_en=0 from first mode until the cycle after load.
- HOUR_MAX=11, cur_hr=11. Enter SET_HR, press up once -> edit_hr=0. Down twice -> 10 committed.
- Button glitch high for 1 cycle -> no pulse. Hold up 20 cycles in SET_MIN from 58 -> pulses at accept, +8, +11, +14, +17 cycles; the value wraps through 59->0 and ends at 3.
- In RUN with cur_hr=0, toggle spring_szn 1->0 -> one cycle with load=1, load_hr_only=1, load_hr=23. Holding spring_szn low yields no further load.
- Enter SET_HR, press up, idle 50 cycles -> return to RUN, run_en=1, no load. A DST edge during SET_MIN is dropped, and the commit loads the edited values unchanged.
